icache_fsm_nway: RTL and testbench

- Main control FSM for the next-generation L1 instruction cache.
- Generalises the 2-way, single-beat controller to WAY ways and multi-word line refill over a burst memory interface, with critical-word-first ordering.
- Adds a flush that arrives during a refill: the refill completes and the fetch result is squashed.
- Sits between the fetch pipeline, the request buffer (rbuf), the LRU unit and the Data/TagV arrays.

---
 rtl/icache_fsm_nway.sv | 215 +++++++++++++++++++++
 tb/tb_icache_fsm_nway.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fsm_nway.sv
// L1 instruction-cache control FSM: N-way hit resolution, critical-word-first
// burst refill into a latched victim way, and squashing of a flushed refill.
module icache_fsm_nway #(
  parameter int unsigned WAY          = 4,
  parameter int unsigned OFFSET_WIDTH = 2,
  parameter int unsigned WAYW         = $clog2(WAY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_icache_valid,
  output logic                    icache_pipe_ready,
  input  logic                    pipe_icache_opflag,
  input  logic [31:0]             pipe_icache_ctrl,
  output logic                    icache_mem_req,
  output logic [1:0]              icache_mem_size,
  output logic [7:0]              icache_mem_len,
  input  logic                    mem_icache_addrOK,
  input  logic                    mem_icache_dataOK,
  output logic                    FSM_rbuf_we,
  input  logic [31:0]             FSM_rbuf_addr,
  input  logic [WAY-1:0]          FSM_hit,
  input  logic [WAY-1:0]          FSM_victim,
  output logic [WAY-1:0]          FSM_use,
  output logic [WAY-1:0]          FSM_Data_we,
  output logic [WAY-1:0]          FSM_TagV_we,
  output logic [OFFSET_WIDTH-1:0] FSM_refill_word,
  output logic [WAYW-1:0]         FSM_choose_way,
  output logic                    FSM_choose_return,
  output logic [OFFSET_WIDTH-1:0] FSM_choose_word,
  output logic                    FSM_send_nop,
  output logic                    FSM_op_done
);

  localparam int unsigned WORDS = 1 << OFFSET_WIDTH;
  localparam int unsigned CNTW  = OFFSET_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FLUSH,
    S_OP,
    S_MREQ,
    S_REFILL,
    S_REPLACE_HOLD,
    S_REPLACE
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [WAY-1:0]  vic, vic_nxt;
  logic            flush_pend, flush_pend_nxt;

  logic                    stall;
  logic                    flush;
  logic                    hit_any;
  logic [WAY-1:0]          hit_oh;
  logic [WAYW-1:0]         hit_idx;
  logic                    last_beat;
  logic [OFFSET_WIDTH-1:0] rbuf_word;
  logic                    unused_bits;

  assign stall       = pipe_icache_ctrl[0];
  assign flush       = pipe_icache_ctrl[1];
  assign rbuf_word   = FSM_rbuf_addr[OFFSET_WIDTH+1:2];
  assign hit_any     = |FSM_hit;
  assign last_beat   = mem_icache_dataOK && (cnt == CNTW'(WORDS - 1));
  assign unused_bits = ^{FSM_rbuf_addr[31:OFFSET_WIDTH+2], FSM_rbuf_addr[1:0],
                         pipe_icache_ctrl[31:2]};

  assign FSM_choose_word = rbuf_word;

  // Lowest-index hitting way wins when several ways report a hit.
  always_comb begin
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = WAY - 1; i >= 0; i--) begin
      if (FSM_hit[i]) begin
        hit_idx = WAYW'(i);
        hit_oh  = WAY'(1) << i;
      end
    end
  end

  function automatic state_t decode_req(input logic valid, input logic opflag);
    if (!valid)     return S_IDLE;
    else if (opflag) return S_OP;
    else            return S_LOOKUP;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      vic        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      vic        <= vic_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    vic_nxt           = vic;
    flush_pend_nxt    = flush_pend;
    icache_pipe_ready = 1'b0;
    icache_mem_req    = 1'b0;
    icache_mem_size   = 2'd0;
    icache_mem_len    = 8'd0;
    FSM_rbuf_we       = 1'b0;
    FSM_use           = '0;
    FSM_Data_we       = '0;
    FSM_TagV_we       = '0;
    FSM_refill_word   = '0;
    FSM_choose_way    = '0;
    FSM_choose_return = 1'b0;
    FSM_send_nop      = 1'b0;
    FSM_op_done       = 1'b0;

    // Outputs stay idle for the whole reset cycle.
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          state_nxt         = decode_req(pipe_icache_valid, pipe_icache_opflag);
          icache_pipe_ready = !(pipe_icache_valid && pipe_icache_opflag);
          FSM_rbuf_we       = pipe_icache_valid && !pipe_icache_opflag;
        end

        S_LOOKUP: begin
          if (!hit_any) begin
            if (flush) begin
              state_nxt = S_FLUSH;
            end else begin
              state_nxt = S_MREQ;
              vic_nxt   = FSM_victim;
            end
          end else if (flush) begin
            state_nxt         = S_FLUSH;
            icache_pipe_ready = 1'b1;
            FSM_rbuf_we       = 1'b1;
            FSM_send_nop      = 1'b1;
          end else if (pipe_icache_valid && pipe_icache_opflag) begin
            state_nxt = S_OP;
          end else begin
            state_nxt         = pipe_icache_valid ? S_LOOKUP : S_IDLE;
            icache_pipe_ready = 1'b1;
            FSM_rbuf_we       = pipe_icache_valid;
            FSM_choose_way    = hit_idx;
            FSM_use           = hit_oh;
          end
        end

        S_FLUSH: begin
          state_nxt         = decode_req(pipe_icache_valid, pipe_icache_opflag);
          icache_pipe_ready = 1'b1;
          FSM_send_nop      = 1'b1;
          FSM_rbuf_we       = pipe_icache_valid && !pipe_icache_opflag;
        end

        S_OP: begin
          state_nxt   = S_IDLE;
          FSM_op_done = 1'b1;
        end

        S_MREQ: begin
          icache_mem_req  = 1'b1;
          icache_mem_size = 2'd2;
          icache_mem_len  = 8'(WORDS - 1);
          if (flush) flush_pend_nxt = 1'b1;
          if (mem_icache_addrOK) begin
            state_nxt = S_REFILL;
            cnt_nxt   = '0;
          end
        end

        // Beats arrive critical word first, wrapping within the line.
        S_REFILL: begin
          FSM_refill_word = OFFSET_WIDTH'(rbuf_word + cnt[OFFSET_WIDTH-1:0]);
          if (mem_icache_dataOK) begin
            FSM_Data_we = vic;
            if (last_beat) begin
              FSM_TagV_we       = vic;
              FSM_use           = vic;
              FSM_choose_return = 1'b1;
              icache_pipe_ready = 1'b1;
              FSM_rbuf_we       = 1'b1;
              FSM_send_nop      = flush_pend || flush;
              flush_pend_nxt    = 1'b0;
              cnt_nxt           = '0;
              state_nxt         = stall ? S_REPLACE_HOLD : S_REPLACE;
            end else begin
              cnt_nxt = cnt + CNTW'(1);
              if (flush) flush_pend_nxt = 1'b1;
            end
          end else if (flush) begin
            flush_pend_nxt = 1'b1;
          end
        end

        S_REPLACE_HOLD: begin
          state_nxt         = S_REPLACE;
          icache_pipe_ready = 1'b1;
        end

        S_REPLACE: begin
          state_nxt = decode_req(pipe_icache_valid, pipe_icache_opflag);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fsm_nway.sv
// Bench for icache_fsm_nway: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_icache_fsm_nway;

  localparam int unsigned WAY   = 4;
  localparam int unsigned OW    = 2;
  localparam int unsigned WAYW  = 2;
  localparam int unsigned WORDS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_icache_valid;
  logic            icache_pipe_ready;
  logic            pipe_icache_opflag;
  logic [31:0]     pipe_icache_ctrl;
  logic            icache_mem_req;
  logic [1:0]      icache_mem_size;
  logic [7:0]      icache_mem_len;
  logic            mem_icache_addrOK;
  logic            mem_icache_dataOK;
  logic            FSM_rbuf_we;
  logic [31:0]     FSM_rbuf_addr;
  logic [WAY-1:0]  FSM_hit;
  logic [WAY-1:0]  FSM_victim;
  logic [WAY-1:0]  FSM_use;
  logic [WAY-1:0]  FSM_Data_we;
  logic [WAY-1:0]  FSM_TagV_we;
  logic [OW-1:0]   FSM_refill_word;
  logic [WAYW-1:0] FSM_choose_way;
  logic            FSM_choose_return;
  logic [OW-1:0]   FSM_choose_word;
  logic            FSM_send_nop;
  logic            FSM_op_done;

  always #5 clk = ~clk;

  icache_fsm_nway #(.WAY(WAY), .OFFSET_WIDTH(OW), .WAYW(WAYW)) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_icache_valid (pipe_icache_valid),
    .icache_pipe_ready (icache_pipe_ready),
    .pipe_icache_opflag(pipe_icache_opflag),
    .pipe_icache_ctrl  (pipe_icache_ctrl),
    .icache_mem_req    (icache_mem_req),
    .icache_mem_size   (icache_mem_size),
    .icache_mem_len    (icache_mem_len),
    .mem_icache_addrOK (mem_icache_addrOK),
    .mem_icache_dataOK (mem_icache_dataOK),
    .FSM_rbuf_we       (FSM_rbuf_we),
    .FSM_rbuf_addr     (FSM_rbuf_addr),
    .FSM_hit           (FSM_hit),
    .FSM_victim        (FSM_victim),
    .FSM_use           (FSM_use),
    .FSM_Data_we       (FSM_Data_we),
    .FSM_TagV_we       (FSM_TagV_we),
    .FSM_refill_word   (FSM_refill_word),
    .FSM_choose_way    (FSM_choose_way),
    .FSM_choose_return (FSM_choose_return),
    .FSM_choose_word   (FSM_choose_word),
    .FSM_send_nop      (FSM_send_nop),
    .FSM_op_done       (FSM_op_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: phase of the cache controller as seen from the pipe.
  localparam int M_IDLE = 0, M_LOOKUP = 1, M_FLUSH = 2, M_OP = 3,
                 M_MREQ = 4, M_REFILL = 5, M_HOLD = 6, M_REPL = 7;

  int             m_phase = M_IDLE;
  int             m_beat  = 0;
  logic [WAY-1:0] m_vic   = '0;
  bit             m_pend  = 1'b0;

  bit             e_ready, e_req, e_rbuf_we, e_ret, e_nop, e_op;
  int             e_size, e_len, e_rword, e_way, e_cword;
  logic [WAY-1:0] e_use, e_data_we, e_tagv_we;

  function automatic int next_req(input bit v, input bit op);
    if (!v) return M_IDLE;
    return op ? M_OP : M_LOOKUP;
  endfunction

  always @(negedge clk) begin : model_cmp
    int n_phase, n_beat, hidx;
    logic [WAY-1:0] n_vic, hoh;
    bit n_pend, hany, v, op, fl, st;

    e_ready = 0; e_req = 0; e_rbuf_we = 0; e_ret = 0; e_nop = 0; e_op = 0;
    e_size = 0; e_len = 0; e_rword = 0; e_way = 0;
    e_use = '0; e_data_we = '0; e_tagv_we = '0;
    e_cword = int'((FSM_rbuf_addr >> 2) % WORDS);

    v  = pipe_icache_valid;
    op = pipe_icache_opflag;
    fl = pipe_icache_ctrl[1];
    st = pipe_icache_ctrl[0];

    hany = 0; hidx = 0; hoh = '0;
    for (int i = 0; i < int'(WAY); i++)
      if (FSM_hit[i] && !hany) begin hany = 1; hidx = i; end
    if (hany) hoh[hidx] = 1'b1;

    n_phase = m_phase; n_beat = m_beat; n_vic = m_vic; n_pend = m_pend;

    if (rst) begin
      n_phase = M_IDLE; n_beat = 0; n_vic = '0; n_pend = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          e_ready = !(v && op); e_rbuf_we = v && !op; n_phase = next_req(v, op);
        end
        M_FLUSH: begin
          e_ready = 1; e_nop = 1; e_rbuf_we = v && !op; n_phase = next_req(v, op);
        end
        M_REPL: n_phase = next_req(v, op);
        M_OP: begin e_op = 1; n_phase = M_IDLE; end
        M_LOOKUP: begin
          if (!hany) begin
            if (fl) n_phase = M_FLUSH;
            else begin n_phase = M_MREQ; n_vic = FSM_victim; end
          end else if (fl) begin
            e_ready = 1; e_rbuf_we = 1; e_nop = 1; n_phase = M_FLUSH;
          end else if (v && op) begin
            n_phase = M_OP;
          end else begin
            e_ready = 1; e_way = hidx; e_use = hoh; e_rbuf_we = v;
            n_phase = v ? M_LOOKUP : M_IDLE;
          end
        end
        M_MREQ: begin
          e_req = 1; e_size = 2; e_len = WORDS - 1;
          if (fl) n_pend = 1;
          if (mem_icache_addrOK) begin n_phase = M_REFILL; n_beat = 0; end
        end
        M_REFILL: begin
          e_rword = int'(((FSM_rbuf_addr >> 2) + 32'(m_beat)) % WORDS);
          if (mem_icache_dataOK) begin
            e_data_we = m_vic;
            if (m_beat == int'(WORDS) - 1) begin
              e_tagv_we = m_vic; e_use = m_vic; e_ret = 1; e_ready = 1; e_rbuf_we = 1;
              e_nop = m_pend || fl; n_pend = 0; n_beat = 0;
              n_phase = st ? M_HOLD : M_REPL;
            end else begin
              n_beat = m_beat + 1;
              if (fl) n_pend = 1;
            end
          end else if (fl) begin
            n_pend = 1;
          end
        end
        M_HOLD: begin e_ready = 1; n_phase = M_REPL; end
        default: n_phase = M_IDLE;
      endcase
    end

    chk("model_ready",     32'(icache_pipe_ready), 32'(e_ready));
    chk("model_mem_req",   32'(icache_mem_req),    32'(e_req));
    chk("model_mem_size",  32'(icache_mem_size),   32'(e_size));
    chk("model_mem_len",   32'(icache_mem_len),    32'(e_len));
    chk("model_rbuf_we",   32'(FSM_rbuf_we),       32'(e_rbuf_we));
    chk("model_use",       32'(FSM_use),           32'(e_use));
    chk("model_data_we",   32'(FSM_Data_we),       32'(e_data_we));
    chk("model_tagv_we",   32'(FSM_TagV_we),       32'(e_tagv_we));
    chk("model_rword",     32'(FSM_refill_word),   32'(e_rword));
    chk("model_way",       32'(FSM_choose_way),    32'(e_way));
    chk("model_return",    32'(FSM_choose_return), 32'(e_ret));
    chk("model_cword",     32'(FSM_choose_word),   32'(e_cword));
    chk("model_send_nop",  32'(FSM_send_nop),      32'(e_nop));
    chk("model_op_done",   32'(FSM_op_done),       32'(e_op));

    m_phase = n_phase; m_beat = n_beat; m_vic = n_vic; m_pend = n_pend;
  end

  task automatic drive(input logic v, input logic op, input logic [1:0] c,
                       input logic [WAY-1:0] h, input logic [WAY-1:0] vi,
                       input logic aok, input logic dok, input logic [31:0] a);
    pipe_icache_valid  = v;
    pipe_icache_opflag = op;
    pipe_icache_ctrl   = {30'd0, c};
    FSM_hit            = h;
    FSM_victim         = vi;
    mem_icache_addrOK  = aok;
    mem_icache_dataOK  = dok;
    FSM_rbuf_addr      = a;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One miss from IDLE through the burst; wseq packs the expected word per beat.
  task automatic refill_run(input logic [31:0] a, input logic [WAY-1:0] v,
                            input logic [7:0] wseq, input int flush_beat,
                            input bit stall_last, input int req_wait);
    logic [WAY-1:0] vrot;
    logic [1:0]     c;
    vrot = {v[WAY-2:0], v[WAY-1]};
    drive(1, 0, 2'b00, '0, v, 0, 0, a);
    chk("rf_idle_ready", 32'(icache_pipe_ready), 32'd1);
    tick();
    drive(0, 0, 2'b00, '0, v, 0, 0, a);
    chk("rf_miss_ready", 32'(icache_pipe_ready), 32'd0);
    tick();
    for (int i = 0; i < req_wait; i++) begin
      drive(0, 0, 2'b00, '0, vrot, 0, 0, a);
      chk("rf_req",  32'(icache_mem_req),  32'd1);
      chk("rf_size", 32'(icache_mem_size), 32'd2);
      chk("rf_len",  32'(icache_mem_len),  32'd3);
      tick();
    end
    drive(0, 0, 2'b00, '0, vrot, 1, 0, a);
    chk("rf_req_ok", 32'(icache_mem_req), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        drive(0, 0, 2'b00, '0, vrot, 0, 0, a);
        chk("rf_gap_we",   32'(FSM_Data_we),     32'd0);
        chk("rf_gap_word", 32'(FSM_refill_word), 32'(wseq[3:2]));
        tick();
      end
      c = {k == flush_beat, stall_last && k == 3};
      drive(0, 0, c, '0, (k >= 2) ? vrot : v, 0, 1, a);
      chk("rf_word",    32'(FSM_refill_word),   32'(wseq[2*k +: 2]));
      chk("rf_data_we", 32'(FSM_Data_we),       32'(v));
      chk("rf_tagv_we", 32'(FSM_TagV_we),       (k == 3) ? 32'(v) : 32'd0);
      chk("rf_ready",   32'(icache_pipe_ready), 32'(k == 3));
      chk("rf_return",  32'(FSM_choose_return), 32'(k == 3));
      chk("rf_use",     32'(FSM_use),           (k == 3) ? 32'(v) : 32'd0);
      chk("rf_nop",     32'(FSM_send_nop),      32'(k == 3 && flush_beat >= 0));
      tick();
    end
    if (stall_last) begin
      drive(0, 0, 2'b00, '0, v, 0, 0, a);
      chk("rf_hold_ready", 32'(icache_pipe_ready), 32'd1);
      tick();
    end
    drive(1, 0, 2'b00, '0, v, 0, 0, a);
    chk("rf_repl_ready", 32'(icache_pipe_ready), 32'd0);
    chk("rf_repl_rbuf",  32'(FSM_rbuf_we),       32'd0);
    tick();
    drive(0, 0, 2'b00, 4'b0001, v, 0, 0, a);
    chk("rf_after_ready", 32'(icache_pipe_ready), 32'd1);
    chk("rf_after_way",   32'(FSM_choose_way),    32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, '0, '0, 0, 0, 32'h0000_000C);
    chk("rst_ready", 32'(icache_pipe_ready), 32'd0);
    chk("rst_req",   32'(icache_mem_req),    32'd0);
    chk("rst_cword", 32'(FSM_choose_word),   32'd3);
    tick();
    tick();
    rst = 1'b0;

    // Hit stream on way 2.
    drive(1, 0, 2'b00, '0, '0, 0, 0, 32'h100);
    chk("hs_idle_rbuf", 32'(FSM_rbuf_we), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b00, 4'b0100, 4'b0001, 0, 0, 32'h100);
      chk("hs_ready", 32'(icache_pipe_ready), 32'd1);
      chk("hs_way",   32'(FSM_choose_way),    32'd2);
      chk("hs_use",   32'(FSM_use),           32'b0100);
      tick();
    end
    drive(0, 0, 2'b00, 4'b0110, 4'b0001, 0, 0, 32'h100);
    chk("hs_last_use", 32'(FSM_use), 32'b0010);
    tick();

    refill_run(32'h0000_1008, 4'b0010, 8'h4E, -1, 1'b1, 3);
    refill_run(32'h0000_2000, 4'b0001, 8'hE4,  1, 1'b0, 0);
    refill_run(32'h0000_3004, 4'b1000, 8'h39, -1, 1'b0, 1);

    // Reset in the middle of a burst.
    drive(1, 0, 2'b00, '0, 4'b0100, 0, 0, 32'h40);
    tick();
    drive(0, 0, 2'b00, '0, 4'b0100, 0, 0, 32'h40);
    tick();
    drive(0, 0, 2'b00, '0, 4'b0100, 1, 0, 32'h40);
    tick();
    drive(0, 0, 2'b00, '0, 4'b0100, 0, 1, 32'h40);
    tick();
    drive(0, 0, 2'b00, '0, 4'b0100, 0, 1, 32'h40);
    tick();
    rst = 1'b1;
    drive(0, 0, 2'b00, '0, 4'b0100, 0, 1, 32'h40);
    chk("mr_rst_we",    32'(FSM_Data_we),       32'd0);
    chk("mr_rst_ready", 32'(icache_pipe_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 2'b00, '0, 4'b0100, 0, 1, 32'h40);
    chk("mr_idle_ready", 32'(icache_pipe_ready), 32'd1);
    chk("mr_idle_we",    32'(FSM_Data_we),       32'd0);
    chk("mr_idle_req",   32'(icache_mem_req),    32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [WAY-1:0] h, vi;
      logic [1:0]     c;
      rst = ($urandom_range(0, 199) == 0);
      h   = ($urandom_range(0, 1) == 0) ? '0 : WAY'($urandom);
      vi  = WAY'(1) << $urandom_range(0, WAY - 1);
      c   = {$urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0};
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, c, h, vi,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, $urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
